// File: rtl/simd_wave_pc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : simd_wave_pc
// Brief    : Per-SIMD bank of wavefront PCs with dispatch, branch, halt and
//            done/error reporting; registered fetch PC for the active context.
// Revision : 1.0
// ---------------------------------------------------------------------------
module simd_wave_pc #(
  parameter int PC_WIDTH       = 32,
  parameter int WAVES_PER_SIMD = 5,
  parameter int PC_STEP        = 1,
  localparam int CTX_W         = (WAVES_PER_SIMD > 1) ? $clog2(WAVES_PER_SIMD) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dispatch_valid,
  input  logic [CTX_W-1:0]          dispatch_ctx,
  input  logic [PC_WIDTH-1:0]       dispatch_pc,
  input  logic [CTX_W-1:0]          active_ctx,
  input  logic                      update_pc,
  input  logic                      branch_taken,
  input  logic                      branch_abs,
  input  logic [PC_WIDTH-1:0]       branch_target,
  input  logic                      halt,
  output logic [PC_WIDTH-1:0]       pc_out,
  output logic                      pc_valid,
  output logic [WAVES_PER_SIMD-1:0] wave_live,
  output logic                      all_done,
  output logic                      dispatch_err
);

  localparam logic [PC_WIDTH-1:0] c_step = PC_WIDTH'(PC_STEP);

  logic [PC_WIDTH-1:0]       r_pc [WAVES_PER_SIMD];
  logic [WAVES_PER_SIMD-1:0] r_live;
  logic [PC_WIDTH-1:0]       r_pc_out;
  logic                      r_pc_valid;
  logic                      r_all_done;
  logic                      r_dispatch_err;

  logic [PC_WIDTH-1:0]       w_pc_nxt [WAVES_PER_SIMD];
  logic [WAVES_PER_SIMD-1:0] w_live_nxt;
  logic                      w_disp_in_range;
  logic                      w_disp_live;
  logic                      w_disp_ok;
  logic                      w_act_in_range;
  logic                      w_act_live;
  logic                      w_upd_ok;
  logic [PC_WIDTH-1:0]       w_pc_sel;
  logic                      w_valid_sel;

  // Context indices beyond WAVES_PER_SIMD match no slot, so they read as
  // out-of-range / not live without ever indexing past the arrays.
  always_comb begin
    w_disp_in_range = 1'b0;
    w_disp_live     = 1'b0;
    w_act_in_range  = 1'b0;
    w_act_live      = 1'b0;
    for (int i = 0; i < WAVES_PER_SIMD; i++) begin
      if (dispatch_ctx == CTX_W'(i)) begin
        w_disp_in_range = 1'b1;
        w_disp_live     = r_live[i];
      end
      if (active_ctx == CTX_W'(i)) begin
        w_act_in_range = 1'b1;
        w_act_live     = r_live[i];
      end
    end
    w_disp_ok = dispatch_valid && w_disp_in_range && !w_disp_live;
    w_upd_ok  = update_pc && w_act_in_range && w_act_live;
  end

  // Accepted dispatch needs a dead slot and an update needs a live one, so
  // both can never hit the same context in one cycle.
  always_comb begin
    w_pc_nxt    = r_pc;
    w_live_nxt  = r_live;
    w_pc_sel    = '0;
    w_valid_sel = 1'b0;
    for (int i = 0; i < WAVES_PER_SIMD; i++) begin
      if (w_upd_ok && active_ctx == CTX_W'(i)) begin
        if (halt) begin
          w_live_nxt[i] = 1'b0;
        end else if (branch_taken) begin
          w_pc_nxt[i] = branch_abs ? branch_target : r_pc[i] + branch_target;
        end else begin
          w_pc_nxt[i] = r_pc[i] + c_step;
        end
      end
      if (w_disp_ok && dispatch_ctx == CTX_W'(i)) begin
        w_pc_nxt[i]   = dispatch_pc;
        w_live_nxt[i] = 1'b1;
      end
    end
    for (int i = 0; i < WAVES_PER_SIMD; i++) begin
      if (active_ctx == CTX_W'(i)) begin
        w_pc_sel    = w_pc_nxt[i];
        w_valid_sel = w_live_nxt[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WAVES_PER_SIMD; i++) begin
        r_pc[i] <= '0;
      end
      r_live         <= '0;
      r_pc_out       <= '0;
      r_pc_valid     <= 1'b0;
      r_all_done     <= 1'b1;
      r_dispatch_err <= 1'b0;
    end else begin
      r_pc           <= w_pc_nxt;
      r_live         <= w_live_nxt;
      r_pc_out       <= w_pc_sel;
      r_pc_valid     <= w_valid_sel;
      r_all_done     <= ~|w_live_nxt;
      r_dispatch_err <= dispatch_valid && !w_disp_ok;
    end
  end

  assign pc_out       = r_pc_out;
  assign pc_valid     = r_pc_valid;
  assign wave_live    = r_live;
  assign all_done     = r_all_done;
  assign dispatch_err = r_dispatch_err;

endmodule
`default_nettype wire

// File: tb/tb_simd_wave_pc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_simd_wave_pc
// Brief    : Directed plus random stimulus against an array-based PC model.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_simd_wave_pc;
  localparam int W  = 32;
  localparam int N  = 5;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          dispatch_valid;
  logic [CW-1:0] dispatch_ctx;
  logic [W-1:0]  dispatch_pc;
  logic [CW-1:0] active_ctx;
  logic          update_pc;
  logic          branch_taken;
  logic          branch_abs;
  logic [W-1:0]  branch_target;
  logic          halt;
  logic [W-1:0]  pc_out;
  logic          pc_valid;
  logic [N-1:0]  wave_live;
  logic          all_done;
  logic          dispatch_err;

  always #5 clk = ~clk;

  simd_wave_pc #(.PC_WIDTH(W), .WAVES_PER_SIMD(N), .PC_STEP(1)) dut (
    .clk(clk), .rst(rst),
    .dispatch_valid(dispatch_valid), .dispatch_ctx(dispatch_ctx), .dispatch_pc(dispatch_pc),
    .active_ctx(active_ctx), .update_pc(update_pc), .branch_taken(branch_taken),
    .branch_abs(branch_abs), .branch_target(branch_target), .halt(halt),
    .pc_out(pc_out), .pc_valid(pc_valid), .wave_live(wave_live),
    .all_done(all_done), .dispatch_err(dispatch_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: one PC and one live flag per wave slot.
  logic [W-1:0] m_pc   [N];
  logic         m_live [N];
  logic [W-1:0] e_pc;
  logic         e_valid;
  logic         e_err;
  logic         e_done;
  logic [N-1:0] e_live;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int  a;
    int  d;
    bit  upd;
    bit  dok;
    a = int'(active_ctx);
    d = int'(dispatch_ctx);
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_pc[i]   = '0;
        m_live[i] = 1'b0;
      end
      e_pc = '0; e_valid = 1'b0; e_err = 1'b0;
    end else begin
      dok = dispatch_valid && d < N && !m_live[d < N ? d : 0];
      upd = update_pc && a < N && m_live[a < N ? a : 0];
      e_err = dispatch_valid && !dok;
      if (upd) begin
        if (halt)              m_live[a] = 1'b0;
        else if (!branch_taken) m_pc[a] = m_pc[a] + 1;
        else if (branch_abs)    m_pc[a] = branch_target;
        else                    m_pc[a] = m_pc[a] + branch_target;
      end
      if (dok) begin
        m_pc[d]   = dispatch_pc;
        m_live[d] = 1'b1;
      end
      e_pc    = (a < N) ? m_pc[a] : '0;
      e_valid = (a < N) ? m_live[a] : 1'b0;
    end
    e_done = 1'b1;
    for (int i = 0; i < N; i++) begin
      e_live[i] = m_live[i];
      if (m_live[i]) e_done = 1'b0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("pc_out",       pc_out,            e_pc);
    check("pc_valid",     W'(pc_valid),      W'(e_valid));
    check("wave_live",    W'(wave_live),     W'(e_live));
    check("all_done",     W'(all_done),      W'(e_done));
    check("dispatch_err", W'(dispatch_err),  W'(e_err));
  endtask

  task automatic drive(input logic dv, input int dctx, input logic [W-1:0] dpc,
                       input int actx, input logic up, input logic bt, input logic ba,
                       input logic [W-1:0] tgt, input logic h);
    dispatch_valid = dv;   dispatch_ctx  = CW'(dctx); dispatch_pc = dpc;
    active_ctx     = CW'(actx); update_pc = up; branch_taken = bt;
    branch_abs     = ba;   branch_target = tgt;       halt        = h;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    dispatch_valid = 0; dispatch_ctx = 0; dispatch_pc = 0; active_ctx = 0;
    update_pc = 0; branch_taken = 0; branch_abs = 0; branch_target = 0; halt = 0;
    tick();
    check("rst_pc_out", pc_out, '0);
    check("rst_all_done", W'(all_done), W'(1));
    rst = 1'b0;

    // Dispatch ctx2 then step three times.
    drive(1, 2, 32'h100, 2, 0, 0, 0, 0, 0);
    check("disp_pc", pc_out, 32'h100);
    drive(0, 0, 0, 2, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 2, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 2, 1, 0, 0, 0, 0);
    check("step3", pc_out, 32'h103);
    check("not_done", W'(all_done), '0);

    // Relative -3, absolute 0x40, then wrap at the top of the address space.
    drive(0, 0, 0, 2, 1, 1, 0, 32'hFFFF_FFFD, 0);
    check("rel_branch", pc_out, 32'h100);
    drive(0, 0, 0, 2, 1, 1, 1, 32'h40, 0);
    check("abs_branch", pc_out, 32'h40);
    drive(0, 0, 0, 2, 1, 1, 1, 32'hFFFF_FFFF, 0);
    drive(0, 0, 0, 2, 1, 0, 0, 0, 0);
    check("wrap", pc_out, 32'h0);

    // Concurrent dispatch and update on different slots; rejected dispatches.
    drive(1, 1, 32'h20, 2, 1, 0, 0, 0, 0);
    drive(1, 0, 32'h10, 1, 1, 0, 0, 0, 0);
    check("upd_ctx1", pc_out, 32'h21);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("switch_ctx0", pc_out, 32'h10);
    drive(1, 1, 32'h99, 1, 0, 0, 0, 0, 0);
    check("dup_err", W'(dispatch_err), W'(1));
    check("dup_keep", pc_out, 32'h21);
    drive(1, 5, 32'h99, 1, 0, 0, 0, 0, 0);
    check("range_err", W'(dispatch_err), W'(1));
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
    check("err_pulse", W'(dispatch_err), '0);

    // Halt with same-cycle dispatch to the halting slot, then re-dispatch.
    drive(1, 1, 32'h77, 1, 1, 1, 1, 32'h55, 1);
    check("halt_err", W'(dispatch_err), W'(1));
    check("halt_valid", W'(pc_valid), '0);
    check("halt_pc", pc_out, 32'h21);
    drive(1, 1, 32'h30, 1, 0, 0, 0, 0, 0);
    check("redisp", pc_out, 32'h30);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 1, 0, 0, 0, 1);
    drive(0, 0, 0, 2, 1, 0, 0, 0, 1);
    check("all_done", W'(all_done), W'(1));

    // Updates on a dead slot and on an out-of-range context.
    drive(0, 0, 0, 3, 1, 0, 0, 0, 0);
    check("dead_valid", W'(pc_valid), '0);
    drive(0, 0, 0, 7, 1, 0, 0, 0, 0);
    check("oor_pc", pc_out, '0);

    // Random traffic with occasional reset.
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 49) == 0);
      drive(logic'($urandom_range(0, 2) == 0), $urandom_range(0, 7), $urandom,
            ($urandom_range(0, 5) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4),
            logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) == 0),
            logic'($urandom_range(0, 1)),
            ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 16)) - 32'd8 : $urandom,
            logic'($urandom_range(0, 9) == 0));
    end

    // Mid-run reset with waves live.
    rst = 1'b0;
    drive(1, 4, 32'hABC, 4, 0, 0, 0, 0, 0);
    rst = 1'b1;
    drive(1, 3, 32'h123, 4, 1, 0, 0, 0, 0);
    check("mid_rst_live", W'(wave_live), '0);
    check("mid_rst_pc", pc_out, '0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
